// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C widths and target state encoding
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADDR      = 3'd1,
        ADDR_ACK  = 3'd2,
        RX        = 3'd3,
        RX_ACK    = 3'd4,
        TX        = 3'd5,
        TX_ACK    = 3'd6,
        WAIT_STOP = 3'd7
    } state_t;

endpackage

// File: rtl/i2c_slave_target_if.sv
// rtl/i2c_slave_target_if.sv - bus pins and local byte interface of the I2C target
// slave modport (the target): scl_in, sda_in, tx_data in; sda_oe, rx_data,
// rx_valid, tx_req, rw_flag, busy out. master modport is the mirror image.
interface i2c_slave_target_if;
    import i2c_pkg::*;

    logic                  scl_in;
    logic                  sda_in;
    logic                  sda_oe;
    logic [I2C_DATA_W-1:0] rx_data;
    logic                  rx_valid;
    logic [I2C_DATA_W-1:0] tx_data;
    logic                  tx_req;
    logic                  rw_flag;
    logic                  busy;

    modport slave (
        input  scl_in, sda_in, tx_data,
        output sda_oe, rx_data, rx_valid, tx_req, rw_flag, busy
    );

    modport master (
        output scl_in, sda_in, tx_data,
        input  sda_oe, rx_data, rx_valid, tx_req, rw_flag, busy
    );

endinterface

// File: rtl/i2c_line_cond.sv
// rtl/i2c_line_cond.sv - SCL/SDA synchronizer, optional glitch filter, edge and START/STOP detect
// Ports: clock, reset (sync, active-high); scl_raw, sda_raw async pins in;
// sda conditioned level, scl_rise, scl_fall, start_det, stop_det single-cycle pulses out.
// Optional filter enabled by macro I2C_SLV_GLITCH_FILTER_EN.
module i2c_line_cond #(
    parameter int FILTER_LEN = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic scl_raw,
    input  logic sda_raw,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_f;
    logic       sda_f;
    logic       scl_q;
    logic       sda_q;

    // Reset to 1 so an idle bus produces no edges when reset is released.
    always_ff @(posedge clock) begin
        if (reset) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], scl_raw};
            sda_sync <= {sda_sync[0], sda_raw};
        end
    end

`ifdef I2C_SLV_GLITCH_FILTER_EN
    localparam int CNT_W = $clog2(FILTER_LEN + 1);

    logic [CNT_W-1:0] scl_cnt;
    logic [CNT_W-1:0] sda_cnt;

    // Output follows the input only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clock) begin
        if (reset) begin
            scl_f   <= 1'b1;
            sda_f   <= 1'b1;
            scl_cnt <= '0;
            sda_cnt <= '0;
        end else begin
            if (scl_sync[1] == scl_f) begin
                scl_cnt <= '0;
            end else if (scl_cnt == CNT_W'(FILTER_LEN - 1)) begin
                scl_f   <= scl_sync[1];
                scl_cnt <= '0;
            end else begin
                scl_cnt <= scl_cnt + 1'b1;
            end
            if (sda_sync[1] == sda_f) begin
                sda_cnt <= '0;
            end else if (sda_cnt == CNT_W'(FILTER_LEN - 1)) begin
                sda_f   <= sda_sync[1];
                sda_cnt <= '0;
            end else begin
                sda_cnt <= sda_cnt + 1'b1;
            end
        end
    end
`else
    // Unfiltered build: FILTER_LEN is kept in the parameter list but has no effect.
    if (FILTER_LEN >= 0) begin : g_bypass
        assign scl_f = scl_sync[1];
        assign sda_f = sda_sync[1];
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_q <= scl_f;
            sda_q <= sda_f;
        end
    end

    assign sda       = sda_f;
    assign scl_rise  = scl_f & ~scl_q;
    assign scl_fall  = ~scl_f & scl_q;
    assign start_det = sda_q & ~sda_f & scl_f;
    assign stop_det  = ~sda_q & sda_f & scl_f;

endmodule

// File: rtl/i2c_slave_target.sv
// rtl/i2c_slave_target.sv - 7-bit address I2C target with byte strobe rx and request-driven tx
// Ports: clock, reset (sync, active-high); bus (i2c_slave_target_if.slave):
// scl_in/sda_in pins, sda_oe open-drain pull, rx_data/rx_valid write bytes,
// tx_data/tx_req read bytes, rw_flag, busy.
// Optional glitch filter on the pins: macro I2C_SLV_GLITCH_FILTER_EN.
module i2c_slave_target
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR = 7'b1110101,
    parameter int                    FILTER_LEN = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    i2c_slave_target_if.slave    bus
);

    logic sda;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    i2c_line_cond #(
        .FILTER_LEN (FILTER_LEN)
    ) u_line_cond (
        .clock     (clock),
        .reset     (reset),
        .scl_raw   (bus.scl_in),
        .sda_raw   (bus.sda_in),
        .sda       (sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    state_t                state;
    logic [2:0]            bit_cnt;
    logic [I2C_DATA_W-1:0] shreg;
    logic                  ack_phase;   // 1 = ACK slot in progress, waiting for its closing fall
    logic                  rx_pend;
    logic                  sda_oe;
    logic [I2C_DATA_W-1:0] rx_data;
    logic                  rx_valid;
    logic                  tx_req;
    logic                  rw_flag;
    logic                  busy;

    logic [I2C_DATA_W-1:0] byte_in;
    logic                  addr_hit;

    assign byte_in  = {shreg[I2C_DATA_W-2:0], sda};
    // General call (address 0) is never claimed.
    assign addr_hit = (byte_in[7:1] == SLAVE_ADDR) && (byte_in[7:1] != '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            ack_phase <= 1'b0;
            rx_pend   <= 1'b0;
            sda_oe    <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            tx_req    <= 1'b0;
            rw_flag   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            tx_req   <= 1'b0;
            rx_valid <= rx_pend;
            rx_pend  <= 1'b0;
            if (start_det) begin
                state     <= ADDR;
                bit_cnt   <= '0;
                sda_oe    <= 1'b0;
                busy      <= 1'b0;
                ack_phase <= 1'b0;
            end else if (stop_det) begin
                state     <= IDLE;
                sda_oe    <= 1'b0;
                busy      <= 1'b0;
                ack_phase <= 1'b0;
            end else begin
                case (state)
                    IDLE: ;
                    ADDR: begin
                        if (scl_rise) begin
                            shreg   <= byte_in;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                if (addr_hit) begin
                                    rw_flag <= sda;
                                    busy    <= 1'b1;
                                    state   <= ADDR_ACK;
                                end else begin
                                    state <= WAIT_STOP;
                                end
                            end
                        end
                    end
                    // RX_ACK is only reached on writes, so its read branch never fires.
                    ADDR_ACK, RX_ACK: begin
                        if (scl_fall) begin
                            if (!ack_phase) begin
                                sda_oe    <= 1'b1;
                                ack_phase <= 1'b1;
                                tx_req    <= rw_flag;
                            end else begin
                                ack_phase <= 1'b0;
                                bit_cnt   <= '0;
                                if (rw_flag) begin
                                    shreg  <= bus.tx_data;
                                    sda_oe <= ~bus.tx_data[7];
                                    state  <= TX;
                                end else begin
                                    sda_oe <= 1'b0;
                                    state  <= RX;
                                end
                            end
                        end
                    end
                    RX: begin
                        if (scl_rise) begin
                            shreg   <= byte_in;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                rx_data <= byte_in;
                                rx_pend <= 1'b1;
                                state   <= RX_ACK;
                            end
                        end
                    end
                    TX: begin
                        if (scl_fall) begin
                            if (bit_cnt == 3'd7) begin
                                sda_oe <= 1'b0;
                                state  <= TX_ACK;
                            end else begin
                                sda_oe  <= ~shreg[6];
                                shreg   <= {shreg[6:0], 1'b0};
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                    end
                    TX_ACK: begin
                        if (scl_rise && !ack_phase) begin
                            if (!sda) begin
                                tx_req    <= 1'b1;
                                ack_phase <= 1'b1;
                            end else begin
                                busy  <= 1'b0;
                                state <= WAIT_STOP;
                            end
                        end else if (scl_fall && ack_phase) begin
                            ack_phase <= 1'b0;
                            bit_cnt   <= '0;
                            shreg     <= bus.tx_data;
                            sda_oe    <= ~bus.tx_data[7];
                            state     <= TX;
                        end
                    end
                    WAIT_STOP: begin
                        sda_oe <= 1'b0;
                        busy   <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.sda_oe   = sda_oe;
    assign bus.rx_data  = rx_data;
    assign bus.rx_valid = rx_valid;
    assign bus.tx_req   = tx_req;
    assign bus.rw_flag  = rw_flag;
    assign bus.busy     = busy;

endmodule

// File: tb/tb_i2c_slave_target.sv
// tb/tb_i2c_slave_target.sv - directed self-checking bench for i2c_slave_target
module tb_i2c_slave_target;
    import i2c_pkg::*;

    localparam int Q = 4;   // quarter SCL period in clocks

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;
    logic sda_line;

    int n_checks = 0;
    int n_fail   = 0;

    int rx_cnt     = 0;
    int tx_req_cnt = 0;
    int oe_cnt     = 0;
    int busy_cnt   = 0;
    logic [7:0] last_rx = 8'h00;

    i2c_slave_target_if bus ();

    assign sda_line   = sda_m & ~bus.sda_oe;
    assign bus.scl_in = scl_m;
    assign bus.sda_in = sda_line;

    i2c_slave_target dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (bus.rx_valid) begin
            rx_cnt  = rx_cnt + 1;
            last_rx = bus.rx_data;
        end
        if (bus.tx_req) tx_req_cnt = tx_req_cnt + 1;
        if (bus.sda_oe) oe_cnt = oe_cnt + 1;
        if (bus.busy) busy_cnt = busy_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b1; wait_clk(Q);
    endtask

    // One SCL cycle with the master driving 'drive'; samples line and sda_oe mid-high.
    task automatic clock_bit(input logic drive, output logic line, output logic oe);
        sda_m = drive; wait_clk(Q);
        scl_m = 1'b1;  wait_clk(Q);
        line = sda_line;
        oe   = bus.sda_oe;
        wait_clk(Q);
        scl_m = 1'b0;  wait_clk(Q);
    endtask

    task automatic write_byte(input logic [7:0] v, output logic ack_oe);
        logic l, o;
        for (int i = 7; i >= 0; i--) clock_bit(v[i], l, o);
        clock_bit(1'b1, l, ack_oe);
    endtask

    task automatic read_byte(output logic [7:0] d);
        logic l, o;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            clock_bit(1'b1, l, o);
            d = {d[6:0], l};
        end
    endtask

    initial begin
        logic       ack;
        logic       l, o;
        logic [7:0] d;
        int         rx0, tx0, oe0, busy0;

        bus.tx_data = 8'h00;

        // Reset state
        wait_clk(4);
        check_eq("rst_sda_oe", 32'(bus.sda_oe), 32'd0);
        check_eq("rst_rx_data", 32'(bus.rx_data), 32'd0);
        check_eq("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
        check_eq("rst_tx_req", 32'(bus.tx_req), 32'd0);
        check_eq("rst_rw_flag", 32'(bus.rw_flag), 32'd0);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_state", 32'(dut.state), 32'(IDLE));
        reset = 1'b0;
        wait_clk(4);

        // Write 0xE9 to 0x75
        rx0 = rx_cnt;
        i2c_start();
        write_byte(8'hEA, ack);
        check_eq("wr_addr_ack", 32'(ack), 32'd1);
        check_eq("wr_rw_flag", 32'(bus.rw_flag), 32'd0);
        write_byte(8'hE9, ack);
        check_eq("wr_data_ack", 32'(ack), 32'd1);
        check_eq("wr_busy_mid", 32'(bus.busy), 32'd1);
        i2c_stop();
        check_eq("wr_rx_count", 32'(rx_cnt - rx0), 32'd1);
        check_eq("wr_rx_data", 32'(last_rx), 32'hE9);
        check_eq("wr_busy_after_stop", 32'(bus.busy), 32'd0);
        check_eq("wr_state_after_stop", 32'(dut.state), 32'(IDLE));

        // Address mismatch 0x74
        rx0 = rx_cnt; oe0 = oe_cnt; busy0 = busy_cnt;
        i2c_start();
        write_byte(8'hE8, ack);
        check_eq("mm_addr_ack", 32'(ack), 32'd0);
        write_byte(8'h55, ack);
        i2c_stop();
        check_eq("mm_oe_cycles", 32'(oe_cnt - oe0), 32'd0);
        check_eq("mm_rx_count", 32'(rx_cnt - rx0), 32'd0);
        check_eq("mm_busy_cycles", 32'(busy_cnt - busy0), 32'd0);

        // Read 0xA5 (ACK) then 0x3C (NACK)
        tx0 = tx_req_cnt;
        bus.tx_data = 8'hA5;
        i2c_start();
        write_byte(8'hEB, ack);
        check_eq("rd_addr_ack", 32'(ack), 32'd1);
        check_eq("rd_rw_flag", 32'(bus.rw_flag), 32'd1);
        check_eq("rd_tx_req_1", 32'(tx_req_cnt - tx0), 32'd1);
        read_byte(d);
        check_eq("rd_byte0", 32'(d), 32'hA5);
        bus.tx_data = 8'h3C;
        clock_bit(1'b0, l, o);
        read_byte(d);
        check_eq("rd_byte1", 32'(d), 32'h3C);
        clock_bit(1'b1, l, o);
        check_eq("rd_tx_req_2", 32'(tx_req_cnt - tx0), 32'd2);
        check_eq("rd_state_nack", 32'(dut.state), 32'(WAIT_STOP));
        check_eq("rd_busy_nack", 32'(bus.busy), 32'd0);
        check_eq("rd_oe_nack", 32'(bus.sda_oe), 32'd0);
        i2c_stop();
        check_eq("rd_state_stop", 32'(dut.state), 32'(IDLE));

        // Repeated start after 4 data bits
        rx0 = rx_cnt;
        bus.tx_data = 8'hA5;
        i2c_start();
        write_byte(8'hEA, ack);
        check_eq("rs_addr_w_ack", 32'(ack), 32'd1);
        clock_bit(1'b1, l, o);
        clock_bit(1'b0, l, o);
        clock_bit(1'b1, l, o);
        clock_bit(1'b0, l, o);
        i2c_start();
        write_byte(8'hEB, ack);
        check_eq("rs_addr_r_ack", 32'(ack), 32'd1);
        check_eq("rs_rw_flag", 32'(bus.rw_flag), 32'd1);
        check_eq("rs_busy", 32'(bus.busy), 32'd1);
        check_eq("rs_no_rx", 32'(rx_cnt - rx0), 32'd0);
        i2c_stop();
        check_eq("rs_state_stop", 32'(dut.state), 32'(IDLE));

        // Reset during the 5th data bit (that bit is 1, so SDA stays high)
        i2c_start();
        write_byte(8'hEA, ack);
        clock_bit(1'b1, l, o);
        clock_bit(1'b1, l, o);
        clock_bit(1'b1, l, o);
        clock_bit(1'b0, l, o);
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        reset = 1'b1;
        @(negedge clock);
        check_eq("mr_sda_oe", 32'(bus.sda_oe), 32'd0);
        check_eq("mr_rx_data", 32'(bus.rx_data), 32'd0);
        check_eq("mr_rx_valid", 32'(bus.rx_valid), 32'd0);
        check_eq("mr_tx_req", 32'(bus.tx_req), 32'd0);
        check_eq("mr_rw_flag", 32'(bus.rw_flag), 32'd0);
        check_eq("mr_busy", 32'(bus.busy), 32'd0);
        check_eq("mr_state", 32'(dut.state), 32'(IDLE));
        reset = 1'b0;
        scl_m = 1'b0; wait_clk(Q);
        rx0 = rx_cnt;
        i2c_start();
        write_byte(8'hEA, ack);
        check_eq("mr2_addr_ack", 32'(ack), 32'd1);
        write_byte(8'h5A, ack);
        check_eq("mr2_data_ack", 32'(ack), 32'd1);
        i2c_stop();
        check_eq("mr2_rx_count", 32'(rx_cnt - rx0), 32'd1);
        check_eq("mr2_rx_data", 32'(last_rx), 32'h5A);

`ifdef I2C_SLV_GLITCH_FILTER_EN
        // 2-clock low glitch on SDA with SCL high must not look like START
        wait_clk(8);
        sda_m = 1'b0; wait_clk(2);
        sda_m = 1'b1; wait_clk(12);
        check_eq("gl_state", 32'(dut.state), 32'(IDLE));
        check_eq("gl_busy", 32'(bus.busy), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_slave_target.md
Name: i2c_slave_target

Overview:
- I2C target that sits directly downstream of the team's `i2c` master: it terminates the SCL/SDA bus the master drives.
- Matches one 7-bit address and ACKs it. Writes: delivers each received byte on a strobe interface. Reads: fetches bytes from the local side and shifts them out.
- Fully synchronous to the system clock; SCL/SDA are oversampled, never used as clocks.

Parameters:
- SLAVE_ADDR, 7'b1110101, 7-bit address this target answers to.
- FILTER_LEN, 3, stable-sample count for the glitch filter (used only when I2C_SLV_GLITCH_FILTER_EN is defined).

Ports:
- clock  in  1  system clock; SCL period must be at least 8 clock periods.
- reset  in  1  synchronous, active-high reset.
- scl_in  in  1  bus SCL, asynchronous.
- sda_in  in  1  bus SDA, asynchronous.
- sda_oe  out  1  1 = pull SDA low (open-drain); 0 = release.
- rx_data  out  8  last byte received in a write transfer.
- rx_valid  out  1  one-cycle strobe; rx_data is new.
- tx_data  in  8  byte to send on a read; must be stable from the tx_req cycle until the next detected SCL fall.
- tx_req  out  1  one-cycle strobe requesting the next tx_data.
- rw_flag  out  1  R/W bit of the current addressed transfer (1 = read).
- busy  out  1  1 from an address match until STOP or NACK.

Behaviour:
- **Input conditioning**
  - scl_in and sda_in each pass through a 2-flop synchronizer, then a 1-flop history register for edge detection.
  - Edge/condition detection therefore lags the pin by 3 clocks.
  - scl_rise and scl_fall are single-cycle pulses.
  - START = synced SDA falls while synced SCL = 1. STOP = synced SDA rises while synced SCL = 1.
- **Bit timing**
  - Data is sampled on scl_rise.
  - sda_oe changes only on scl_fall, except on START, STOP and reset, where it is forced to 0 the same cycle.
- **States**
  - IDLE: sda_oe = 0, busy = 0. START -> ADDR.
  - ADDR: shift 8 bits MSB first, 3-bit bit counter.
    - After the 8th scl_rise: if bits[7:1] == SLAVE_ADDR, set rw_flag = bit0 and busy = 1, go to ADDR_ACK.
    - Otherwise go to WAIT_STOP.
  - ADDR_ACK: on scl_fall, sda_oe = 1.
    - If rw_flag = 1, pulse tx_req in that same cycle.
    - On the next scl_fall: if rw_flag = 0, release sda_oe and go to RX; if rw_flag = 1, load tx_data into the shifter, drive the MSB (sda_oe = ~bit7) and go to TX.
  - RX: shift 8 bits on scl_rise.
    - After the 8th bit: rx_data updates and rx_valid pulses one cycle later.
    - Then -> RX_ACK.
  - RX_ACK: same ACK drive/release as ADDR_ACK, then -> RX.
  - TX: on each scl_fall, present the next bit.
    - After the 8th bit's scl_fall, release sda_oe and go to TX_ACK.
  - TX_ACK: sample the master's ACK on scl_rise.
    - 0 (ACK): pulse tx_req in that cycle; on the next scl_fall load tx_data and drive its MSB -> TX.
    - 1 (NACK): -> WAIT_STOP.
  - WAIT_STOP: sda_oe = 0, busy = 0. Waits for STOP or START.
- **Boundary rules**
  - START in any state (repeated start): -> ADDR, bit counter = 0, sda_oe = 0, busy = 0, rw_flag held.
  - STOP in any state: -> IDLE, sda_oe = 0, busy = 0. A partial byte is discarded with no rx_valid.
  - START and scl_rise cannot coincide, since SCL is high during START; START takes priority in any case.
  - General-call address 0x00 is not matched.
- **Reset**
  - Asserting reset at any point, including mid-byte, returns the block to IDLE and clears the synchronizers to 1 (bus idle).
  - All outputs reset to 0: sda_oe, rx_data, rx_valid, tx_req, rw_flag, busy.

Optional Feature:
- I2C_SLV_GLITCH_FILTER_EN defined:
  - Each synchronized line passes a filter whose output changes only after FILTER_LEN consecutive equal samples.
  - Adds FILTER_LEN clocks of latency; pulses shorter than FILTER_LEN clocks are suppressed.
- Not defined: no filter, FILTER_LEN is unused, 3-clock detection latency.

Decomposition:
- Package i2c_pkg holds:
  - the state enum (IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT_STOP);
  - I2C_ADDR_W = 7 and I2C_DATA_W = 8, shared with the `i2c` master.
- One sub-module, i2c_line_cond:
  - synchronizer, optional filter, and edge/START/STOP detection;
  - instantiated once and handles both lines.

Test Plan:
- Write: START, 0xEA (0x75+W), data 0xE9, STOP.
  - sda_oe = 1 during both 9th bits; rx_data = 0xE9 with exactly one rx_valid; busy falls at STOP.
- Address mismatch: START, 0xE8 (0x74+W), 0x55, STOP.
  - sda_oe never 1; no rx_valid; busy stays 0.
- Read: START, 0xEB, tx_data = 0xA5, master ACKs the first byte, then tx_data = 0x3C, master NACKs.
  - SDA bits 10100101 then 00111100; tx_req pulses exactly twice; WAIT_STOP after NACK.
- Repeated start: write 0xEA, then START after 4 data bits, then 0xEB.
  - No rx_valid for the partial byte; ACK on 0xEB; rw_flag = 1.
- Reset mid-byte: assert reset during the 5th data bit.
  - Next cycle all outputs are 0 and the state is IDLE; a following full write transfer succeeds.
- With I2C_SLV_GLITCH_FILTER_EN: 2-clock low glitch on SDA while SCL is high.
  - No START detected; state stays IDLE.
